// File: rtl/input_port_controller_pkg.sv
// Shared definitions for the IN-instruction input port: FSM encoding and the
// write-back select code that routes data_input into the register file.
package input_port_controller_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    DONE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } ipc_state_e;

  localparam logic [2:0] WB_SEL_IN = 3'd3;

  function automatic logic is_in_select(input logic [2:0] sel);
    return sel == WB_SEL_IN;
  endfunction

endpackage

// File: rtl/input_port_controller_button_debouncer.sv
// Confirm-button conditioning: two-flop synchroniser, stable-sample counter,
// debounced level and a one-cycle pulse on its rising edge.
module button_debouncer
  import input_port_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  output logic debounced,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d    = button_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = '0;
    // Counter only runs while the synchronised level disagrees; any agreement restarts it.
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  assign debounced   = deb_q;
  assign press_pulse = deb_q & ~deb_prev_q;

endmodule

// File: rtl/input_port_controller.sv
// Input port for the IN instruction: stalls the core, captures the switches on a
// debounced button press and releases the core for exactly one commit cycle.
//
// state        | meaning
// IDLE         | no IN pending
// WAIT_PRESS   | IN pending, prompting the user (waiting_led)
// DONE         | word captured, core commits this cycle
// WAIT_RELEASE | waiting for the button to come up before serving another IN
module input_port_controller
  import input_port_controller_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  input_request,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  button_raw,
  output logic [DATA_WIDTH-1:0] data_input,
  output logic                  input_stall,
  output logic                  input_valid,
  output logic                  waiting_led
);

  ipc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  debounced;
  logic                  press_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock      (clock),
    .reset      (reset),
    .button_raw (button_raw),
    .debounced  (debounced),
    .press_pulse(press_pulse)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    input_valid = 1'b0;
    waiting_led = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A press arriving together with the request is deliberately not looked at here.
        if (input_request) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        waiting_led = 1'b1;
        if (press_pulse) begin
          data_d  = DATA_WIDTH'(switches);
          state_d = DONE;
        end else if (!input_request) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        input_valid = 1'b1;
        state_d     = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!debounced) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data_input  = data_q;
  assign input_stall = input_request & (state_q != DONE);

endmodule

// File: tb/tb_input_port_controller.sv
// Self-checking bench for input_port_controller with a short debounce window and
// a behavioural model of the press/capture/commit protocol.
module tb_input_port_controller;

  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        input_request;
  logic [15:0] switches;
  logic        button_raw;
  logic [31:0] data_input;
  logic        input_stall;
  logic        input_valid;
  logic        waiting_led;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  input_port_controller #(
    .DATA_WIDTH     (32),
    .SW_WIDTH       (16),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .input_request(input_request),
    .switches     (switches),
    .button_raw   (button_raw),
    .data_input   (data_input),
    .input_stall  (input_stall),
    .input_valid  (input_valid),
    .waiting_led  (waiting_led)
  );

  always #5 clock = ~clock;

  // Behavioural model: button level seen two samples late; a new level is believed
  // after DEB consecutive disagreeing samples; a request waits for a believed press,
  // commits once, then needs the button believed up before it can be served again.
  logic [1:0]  m_pipe;
  logic        m_level, m_level_old;
  int          m_run;
  logic        m_waiting, m_commit, m_hold;
  logic [31:0] m_data;

  task automatic model_edge();
    logic pressed_now;
    pressed_now = m_level & ~m_level_old;
    if (!reset) begin
      m_pipe = 2'b00; m_level = 1'b0; m_level_old = 1'b0; m_run = 0;
      m_waiting = 1'b0; m_commit = 1'b0; m_hold = 1'b0; m_data = 32'h0;
      return;
    end
    if (m_commit) begin
      m_commit = 1'b0;
      m_hold   = 1'b1;
    end else if (m_hold) begin
      if (!m_level) m_hold = 1'b0;
    end else if (m_waiting) begin
      if (pressed_now) begin
        m_data    = {16'h0, switches};
        m_waiting = 1'b0;
        m_commit  = 1'b1;
      end else if (!input_request) begin
        m_waiting = 1'b0;
      end
    end else if (input_request) begin
      m_waiting = 1'b1;
    end
    m_level_old = m_level;
    if (m_pipe[1] != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = m_pipe[1];
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_pipe = {m_pipe[0], button_raw};
  endtask

  function automatic logic [34:0] expected_outputs();
    return {input_request & ~m_commit, m_commit, m_waiting, m_data};
  endfunction

  function automatic logic [34:0] actual_outputs();
    return {input_stall, input_valid, waiting_led, data_input};
  endfunction

  task automatic step(input logic r, input logic q, input logic b, input logic [15:0] s);
    reset = r; input_request = q; button_raw = b; switches = s;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'hFFFF);
      n_checks++;
      if (actual_outputs() !== 35'h0) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, actual_outputs(), 35'h0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'hFFFF);
      n_checks++;
      if (input_valid !== 1'b0 || actual_outputs() !== expected_outputs()) begin
        n_bad++;
        $display("FAIL reset_after cyc=%0d got=%h exp=%h", cyc, actual_outputs(), expected_outputs());
      end
    end
  endtask

  task automatic test_clean_in();
    int first_valid, n_valid;
    first_valid = -1; n_valid = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h00A5);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b1, 1'b1, 16'h00A5);
      if (input_valid === 1'b1) begin
        n_valid++;
        if (first_valid < 0) first_valid = k;
      end
      n_checks++;
      if (actual_outputs() !== expected_outputs()) begin
        n_bad++;
        $display("FAIL clean_in cyc=%0d got=%h exp=%h", cyc, actual_outputs(), expected_outputs());
      end
    end
    // Edges from raw press to the commit cycle: 2 sync + DEB debounce + 1 capture;
    // the commit cycle itself is the (2+DEB+2)-th cycle.
    n_checks++;
    if (first_valid != 2 + DEB + 1 || n_valid != 1) begin
      n_bad++;
      $display("FAIL clean_latency got_edge=%0d got_pulses=%0d exp_edge=%0d exp_pulses=1",
               first_valid, n_valid, 2 + DEB + 1);
    end
    n_checks++;
    if (data_input !== 32'h0000_00A5) begin
      n_bad++;
      $display("FAIL clean_data got=%h exp=%h", data_input, 32'h0000_00A5);
    end
  endtask

  task automatic test_back_to_back();
    int n_valid;
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b1, 16'h1234);
      n_valid += int'(input_valid === 1'b1);
      n_checks++;
      if (input_stall !== 1'b1 || actual_outputs() !== expected_outputs()) begin
        n_bad++;
        $display("FAIL b2b_held cyc=%0d got=%h exp=%h", cyc, actual_outputs(), expected_outputs());
      end
    end
    n_checks++;
    if (n_valid != 0 || data_input !== 32'h0000_00A5) begin
      n_bad++;
      $display("FAIL b2b_no_second got_pulses=%0d got_data=%h exp_pulses=0 exp_data=%h",
               n_valid, data_input, 32'h0000_00A5);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, (i >= 10), 16'h1234);
      n_valid += int'(input_valid === 1'b1);
      n_checks++;
      if (actual_outputs() !== expected_outputs()) begin
        n_bad++;
        $display("FAIL b2b_repress cyc=%0d got=%h exp=%h", cyc, actual_outputs(), expected_outputs());
      end
    end
    n_checks++;
    if (n_valid != 1 || data_input !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL b2b_second got_pulses=%0d got_data=%h exp_pulses=1 exp_data=%h",
               n_valid, data_input, 32'h0000_1234);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pattern;
    int n_valid;
    pattern = 16'b1111_1111_1111_0101;
    n_valid = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h00C3);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, pattern[i], 16'h00C3);
      n_valid += int'(input_valid === 1'b1);
      n_checks++;
      if (actual_outputs() !== expected_outputs()) begin
        n_bad++;
        $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, actual_outputs(), expected_outputs());
      end
    end
    n_checks++;
    if (n_valid != 1 || data_input !== 32'h0000_00C3) begin
      n_bad++;
      $display("FAIL bounce_once got_pulses=%0d got_data=%h exp_pulses=1 exp_data=%h",
               n_valid, data_input, 32'h0000_00C3);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'hBEEF);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'hBEEF);
    n_checks++;
    if (waiting_led !== 1'b1 || input_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_waiting got_led=%b got_stall=%b exp_led=1 exp_stall=1", waiting_led, input_stall);
    end
    step(1'b1, 1'b0, 1'b0, 16'hBEEF);
    n_checks++;
    if (waiting_led !== 1'b0 || input_stall !== 1'b0 || input_valid !== 1'b0 ||
        data_input !== 32'h0000_00C3) begin
      n_bad++;
      $display("FAIL abort got=%h exp=%h", actual_outputs(), {3'b000, 32'h0000_00C3});
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 16'h5A5A);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 16'h5A5A);
    n_checks++;
    if (data_input !== 32'h0000_5A5A || waiting_led !== 1'b0 || input_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre got=%h exp=%h", actual_outputs(), {3'b100, 32'h0000_5A5A});
    end
    step(1'b0, 1'b1, 1'b1, 16'h5A5A);
    n_checks++;
    if (data_input !== 32'h0 || waiting_led !== 1'b0 || input_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst got=%h exp_data=0 exp_led=0 exp_valid=0", actual_outputs());
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h5A5A);
      n_checks++;
      if (actual_outputs() !== expected_outputs()) begin
        n_bad++;
        $display("FAIL midrst_after cyc=%0d got=%h exp=%h", cyc, actual_outputs(), expected_outputs());
      end
    end
  endtask

  task automatic test_random();
    logic q, b, r;
    int hold;
    q = 1'b0; b = 1'b0; hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        b    = ~b;
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(DEB + 2, 14);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) q = ~q;
      r = ($urandom_range(0, 199) != 0);
      step(r, q, b, 16'($urandom));
      n_checks++;
      if (actual_outputs() !== expected_outputs()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, actual_outputs(), expected_outputs());
      end
    end
  endtask

  initial begin
    reset = 1'b0; input_request = 1'b0; button_raw = 1'b0; switches = 16'h0;
    m_pipe = 2'b00; m_level = 1'b0; m_level_old = 1'b0; m_run = 0;
    m_waiting = 1'b0; m_commit = 1'b0; m_hold = 1'b0; m_data = 32'h0;
    @(negedge clock);
    test_reset();
    test_clean_in();
    test_back_to_back();
    test_bounce();
    test_abort();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
